// File: rtl/conv2d_systolic_engine.sv
// rtl/conv2d_systolic_engine.sv - KxK correlation over an NxN image, streamed out in raster order
//
// Purpose: K MAC lanes (one per filter row) consume one filter column per
// cycle into a shared accumulator. One result per output pixel is presented
// on a valid/ready stream, formatted by SIGNED/SAT.
// Ports:
//   clk_in    rising-edge clock
//   rst       asynchronous active-low reset
//   start     frame request, honoured only in IDLE
//   img_flat  NxN image, element (r,c) at [(r*N+c)*DATA_W +: DATA_W]
//   filt_flat KxK filter, element (r,c) at [(r*K+c)*DATA_W +: DATA_W]
//   busy      high outside IDLE
//   done      one-cycle pulse after the final result handshake
//   out_valid/out_ready  result handshake
//   out_data/out_row/out_col/out_last  result payload
module conv2d_systolic_engine #(
  parameter int DATA_W = 8,
  parameter int K      = 3,
  parameter int N      = 4,
  parameter int OUT_W  = 8,
  parameter int SIGNED = 0,
  parameter int SAT    = 0,
  localparam int RCW   = ((N - K + 1) > 1) ? $clog2(N - K + 1) : 1
) (
  input  logic                  clk_in,
  input  logic                  rst,
  input  logic                  start,
  input  logic [N*N*DATA_W-1:0] img_flat,
  input  logic [K*K*DATA_W-1:0] filt_flat,
  output logic                  busy,
  output logic                  done,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_W-1:0]      out_data,
  output logic [RCW-1:0]        out_row,
  output logic [RCW-1:0]        out_col,
  output logic                  out_last
);

  localparam int AW  = 2 * DATA_W + $clog2(K * K) + 1;
  localparam int KW  = (K > 1) ? $clog2(K) : 1;
  // Wide enough to hold both the accumulator and the clamp bounds as signed values.
  localparam int EW  = AW + OUT_W + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                  state, state_nxt;
  logic [N*N*DATA_W-1:0]   img_r;
  logic [K*K*DATA_W-1:0]   filt_r;
  logic [RCW-1:0]          row, col;
  logic [KW-1:0]           kc;
  logic signed [AW-1:0]    acc;
  logic signed [AW-1:0]    lane_sum;
  logic signed [AW-1:0]    total;
  logic [OUT_W-1:0]        fmt_val;
  logic                    complete, stall, last_pix, accept;

  // Operands are widened by one bit so signed and unsigned share one signed multiplier.
  function automatic logic signed [AW-1:0] mul(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
    logic signed [DATA_W:0] ea, eb;
    logic signed [AW-1:0]   pa, pb;
    ea = (SIGNED != 0) ? {a[DATA_W-1], a} : {1'b0, a};
    eb = (SIGNED != 0) ? {b[DATA_W-1], b} : {1'b0, b};
    pa = {{(AW-DATA_W-1){ea[DATA_W]}}, ea};
    pb = {{(AW-DATA_W-1){eb[DATA_W]}}, eb};
    return pa * pb;
  endfunction

  always_comb begin
    lane_sum = '0;
    for (int kr = 0; kr < K; kr++) begin
      lane_sum = lane_sum +
        mul(img_r[((int'(row) + kr) * N + int'(col) + int'(kc)) * DATA_W +: DATA_W],
            filt_r[(kr * K + int'(kc)) * DATA_W +: DATA_W]);
    end
  end

  assign total = acc + lane_sum;

  always_comb begin
    logic signed [EW-1:0] wide, smax, smin, umax;
    wide = {{(EW-AW){total[AW-1]}}, total};
    smax = {{(EW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    smin = {{(EW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
    umax = {{(EW-OUT_W){1'b0}}, {OUT_W{1'b1}}};
    fmt_val = wide[OUT_W-1:0];
    if (SAT != 0) begin
      if (SIGNED != 0) begin
        if (wide > smax)      fmt_val = smax[OUT_W-1:0];
        else if (wide < smin) fmt_val = smin[OUT_W-1:0];
      end else begin
        if (wide > umax)      fmt_val = umax[OUT_W-1:0];
        else if (wide < 0)    fmt_val = '0;
      end
    end
  end

  assign complete = (state == RUN) && (kc == KW'(K - 1));
  assign stall    = out_valid && !out_ready;
  assign accept   = out_valid && out_ready;
  assign last_pix = (row == RCW'(N - K)) && (col == RCW'(N - K));
  assign busy     = (state != IDLE);

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (complete && !stall && last_pix) state_nxt = DRAIN;
      DRAIN:   if (accept) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      img_r     <= '0;
      filt_r    <= '0;
      row       <= '0;
      col       <= '0;
      kc        <= '0;
      acc       <= '0;
      done      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_row   <= '0;
      out_col   <= '0;
      out_last  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            img_r  <= img_flat;
            filt_r <= filt_flat;
            row    <= '0;
            col    <= '0;
            kc     <= '0;
            acc    <= '0;
          end
        end
        RUN: begin
          if (complete) begin
            // A result still waiting for the consumer freezes the whole engine.
            if (!stall) begin
              out_data  <= fmt_val;
              out_row   <= row;
              out_col   <= col;
              out_valid <= 1'b1;
              out_last  <= last_pix;
              acc       <= '0;
              kc        <= '0;
              if (col == RCW'(N - K)) begin
                col <= '0;
                row <= row + 1'b1;
              end else begin
                col <= col + 1'b1;
              end
            end
          end else begin
            acc <= total;
            kc  <= kc + 1'b1;
            if (accept) out_valid <= 1'b0;
          end
        end
        DRAIN: begin
          if (accept) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            done      <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_conv2d_systolic_engine.sv
// tb/tb_conv2d_systolic_engine.sv - directed self-checking bench for conv2d_systolic_engine
module tb_conv2d_systolic_engine;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // a: defaults (unsigned, wrap); b: unsigned saturate; c: signed saturate; d: K=2 N=5
  logic         a_start, a_busy, a_done, a_valid, a_ready, a_last;
  logic [127:0] a_img;
  logic [71:0]  a_filt;
  logic [7:0]   a_data;
  logic [0:0]   a_row, a_col;

  logic         b_start, b_busy, b_done, b_valid, b_ready, b_last;
  logic [127:0] b_img;
  logic [71:0]  b_filt;
  logic [7:0]   b_data;
  logic [0:0]   b_row, b_col;

  logic         c_start, c_busy, c_done, c_valid, c_ready, c_last;
  logic [127:0] c_img;
  logic [71:0]  c_filt;
  logic [7:0]   c_data;
  logic [0:0]   c_row, c_col;

  logic         d_start, d_busy, d_done, d_valid, d_ready, d_last;
  logic [199:0] d_img;
  logic [31:0]  d_filt;
  logic [7:0]   d_data;
  logic [1:0]   d_row, d_col;

  conv2d_systolic_engine u_a (
    .clk_in(clk), .rst(rst), .start(a_start), .img_flat(a_img), .filt_flat(a_filt),
    .busy(a_busy), .done(a_done), .out_valid(a_valid), .out_ready(a_ready),
    .out_data(a_data), .out_row(a_row), .out_col(a_col), .out_last(a_last));

  conv2d_systolic_engine #(.SAT(1)) u_b (
    .clk_in(clk), .rst(rst), .start(b_start), .img_flat(b_img), .filt_flat(b_filt),
    .busy(b_busy), .done(b_done), .out_valid(b_valid), .out_ready(b_ready),
    .out_data(b_data), .out_row(b_row), .out_col(b_col), .out_last(b_last));

  conv2d_systolic_engine #(.SIGNED(1), .SAT(1)) u_c (
    .clk_in(clk), .rst(rst), .start(c_start), .img_flat(c_img), .filt_flat(c_filt),
    .busy(c_busy), .done(c_done), .out_valid(c_valid), .out_ready(c_ready),
    .out_data(c_data), .out_row(c_row), .out_col(c_col), .out_last(c_last));

  conv2d_systolic_engine #(.K(2), .N(5)) u_d (
    .clk_in(clk), .rst(rst), .start(d_start), .img_flat(d_img), .filt_flat(d_filt),
    .busy(d_busy), .done(d_done), .out_valid(d_valid), .out_ready(d_ready),
    .out_data(d_data), .out_row(d_row), .out_col(d_col), .out_last(d_last));

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  int exp1 [4] = '{54, 63, 90, 99};
  int got [8];
  int n, na, nb, nd, er, ec;
  logic ev;

  initial begin
    a_start = 0; b_start = 0; c_start = 0; d_start = 0;
    a_ready = 1; b_ready = 1; c_ready = 1; d_ready = 1;
    a_img = '0; b_img = '0; c_img = '0; d_img = '0;
    a_filt = '0; b_filt = '0; c_filt = '0; d_filt = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(a_busy), 0);
    check("rst_valid", 32'(a_valid), 0);
    check("rst_done", 32'(a_done), 0);
    check("rst_data", 32'(a_data), 0);
    check("rst_last", 32'(a_last), 0);
    rst = 1;
    @(negedge clk);

    // 1: img(r,c)=4r+c+1, filter of ones, ready held high
    for (int r = 0; r < 4; r++)
      for (int cc = 0; cc < 4; cc++) a_img[(r*4+cc)*8 +: 8] = 8'(4*r + cc + 1);
    for (int i = 0; i < 9; i++) a_filt[i*8 +: 8] = 8'd1;
    a_start = 1;
    @(negedge clk);
    a_start = 0;
    check("t1_busy0", 32'(a_busy), 1);
    for (int cyc = 1; cyc <= 14; cyc++) begin
      @(negedge clk);
      ev = (cyc % 3 == 0) && (cyc <= 12);
      check("t1_valid", 32'(a_valid), 32'(ev));
      check("t1_done", 32'(a_done), 32'(cyc == 13));
      check("t1_busy", 32'(a_busy), 32'(cyc < 13));
      if (ev) begin
        n = cyc / 3 - 1;
        check("t1_data", 32'(a_data), 32'(exp1[n]));
        check("t1_row", 32'(a_row), 32'(n / 2));
        check("t1_col", 32'(a_col), 32'(n % 2));
        check("t1_last", 32'(a_last), 32'(n == 3));
      end
    end

    // 2: back-pressure for 10 cycles on the first result
    a_start = 1;
    @(negedge clk);
    a_start = 0;
    repeat (3) @(negedge clk);
    check("t2_first_valid", 32'(a_valid), 1);
    a_ready = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t2_hold_valid", 32'(a_valid), 1);
      check("t2_hold_data", 32'(a_data), 54);
      check("t2_hold_pos", {a_row, a_col}, 0);
      check("t2_hold_last", 32'(a_last), 0);
    end
    a_ready = 1;
    n = 0; nd = 0;
    for (int i = 0; i < 20; i++) begin
      if (a_valid && n < 8) begin
        got[n] = 32'(a_data);
        n++;
      end
      if (a_done) nd++;
      @(negedge clk);
    end
    check("t2_count", n, 4);
    for (int i = 0; i < 4; i++) check("t2_order", got[i], exp1[i]);
    check("t2_done_cnt", nd, 1);
    check("t2_idle", 32'(a_busy), 0);

    // 3: 100*100*9 = 90000 -> wrap 144, saturate 255
    for (int i = 0; i < 16; i++) begin
      a_img[i*8 +: 8] = 8'd100;
      b_img[i*8 +: 8] = 8'd100;
    end
    for (int i = 0; i < 9; i++) begin
      a_filt[i*8 +: 8] = 8'd100;
      b_filt[i*8 +: 8] = 8'd100;
    end
    a_start = 1; b_start = 1;
    @(negedge clk);
    a_start = 0; b_start = 0;
    na = 0; nb = 0;
    for (int cyc = 1; cyc <= 14; cyc++) begin
      @(negedge clk);
      if (a_valid) begin check("t3_wrap", 32'(a_data), 144); na++; end
      if (b_valid) begin check("t3_sat", 32'(b_data), 255); nb++; end
    end
    check("t3_wrap_cnt", na, 4);
    check("t3_sat_cnt", nb, 4);

    // 4: signed saturation, both polarities
    for (int i = 0; i < 16; i++) c_img[i*8 +: 8] = 8'h80;
    for (int i = 0; i < 9; i++) c_filt[i*8 +: 8] = 8'h7F;
    c_start = 1;
    @(negedge clk);
    c_start = 0;
    n = 0;
    for (int cyc = 1; cyc <= 14; cyc++) begin
      @(negedge clk);
      if (c_valid) begin check("t4_neg_sat", 32'(c_data), 32'h80); n++; end
    end
    check("t4_neg_cnt", n, 4);
    for (int i = 0; i < 9; i++) c_filt[i*8 +: 8] = 8'h81;
    c_start = 1;
    @(negedge clk);
    c_start = 0;
    n = 0;
    for (int cyc = 1; cyc <= 14; cyc++) begin
      @(negedge clk);
      if (c_valid) begin check("t4_pos_sat", 32'(c_data), 32'h7F); n++; end
    end
    check("t4_pos_cnt", n, 4);

    // 5a: reset in the middle of a frame
    for (int r = 0; r < 4; r++)
      for (int cc = 0; cc < 4; cc++) a_img[(r*4+cc)*8 +: 8] = 8'(4*r + cc + 1);
    for (int i = 0; i < 9; i++) a_filt[i*8 +: 8] = 8'd1;
    a_ready = 0;
    a_start = 1;
    @(negedge clk);
    a_start = 0;
    repeat (5) @(negedge clk);
    check("t5_pre_valid", 32'(a_valid), 1);
    rst = 0;
    #1;
    check("t5_async_valid", 32'(a_valid), 0);
    check("t5_async_data", 32'(a_data), 0);
    check("t5_async_busy", 32'(a_busy), 0);
    check("t5_async_last", 32'(a_last), 0);
    @(negedge clk);
    rst = 1;
    a_ready = 1;
    nd = 0; n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (a_done) nd++;
      if (a_valid) n++;
    end
    check("t5_no_done", nd, 0);
    check("t5_no_result", n, 0);

    // 5b: a second start inside a frame is ignored
    a_start = 1;
    @(negedge clk);
    a_start = 0;
    n = 0; nd = 0;
    for (int cyc = 1; cyc <= 16; cyc++) begin
      @(negedge clk);
      a_start = (cyc == 4);
      if (a_valid && n < 8) begin got[n] = 32'(a_data); n++; end
      if (a_done) nd++;
    end
    a_start = 0;
    check("t5_count", n, 4);
    for (int i = 0; i < 4; i++) check("t5_values", got[i], exp1[i]);
    check("t5_done_cnt", nd, 1);

    // 6: K=2, N=5, diagonal filter, img(r,c)=5r+c
    for (int r = 0; r < 5; r++)
      for (int cc = 0; cc < 5; cc++) d_img[(r*5+cc)*8 +: 8] = 8'(5*r + cc);
    d_filt = {8'd1, 8'd0, 8'd0, 8'd1};
    d_start = 1;
    @(negedge clk);
    d_start = 0;
    nd = 0;
    for (int cyc = 1; cyc <= 34; cyc++) begin
      @(negedge clk);
      ev = (cyc % 2 == 0) && (cyc <= 32);
      check("t6_valid", 32'(d_valid), 32'(ev));
      if (d_done) nd++;
      if (ev) begin
        n = cyc / 2 - 1;
        er = n / 4;
        ec = n % 4;
        check("t6_data", 32'(d_data), 32'(2 * (5 * er + ec) + 6));
        check("t6_row", 32'(d_row), 32'(er));
        check("t6_col", 32'(d_col), 32'(ec));
        check("t6_last", 32'(d_last), 32'(n == 15));
      end
    end
    check("t6_done_cnt", nd, 1);
    check("t6_idle", 32'(d_busy), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
